// File: rtl/vga_pkg.sv
// Shared timing constants, counter widths and small decode helpers for the
// VGA sync generator. The values below describe the standard 640x480 mode.
package vga_pkg;

    // Default timing (pixels per line / lines per frame)
    localparam int H_ACTIVE_D = 640;
    localparam int H_FP_D     = 16;
    localparam int H_SYNC_D   = 96;
    localparam int H_BP_D     = 48;
    localparam int V_ACTIVE_D = 480;
    localparam int V_FP_D     = 10;
    localparam int V_SYNC_D   = 2;
    localparam int V_BP_D     = 33;
    localparam int CLK_DIV_D  = 2;

    // Derived totals and sync windows for the default mode
    localparam int H_TOTAL      = H_ACTIVE_D + H_FP_D + H_SYNC_D + H_BP_D;
    localparam int V_TOTAL      = V_ACTIVE_D + V_FP_D + V_SYNC_D + V_BP_D;
    localparam int H_SYNC_START = H_ACTIVE_D + H_FP_D;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC_D - 1;
    localparam int V_SYNC_START = V_ACTIVE_D + V_FP_D;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC_D - 1;

    // Sync pulses are active low
    localparam logic SYNC_ACTIVE = 1'b0;

    // Counter and output widths
    localparam int H_CNT_W = 10;
    localparam int V_CNT_W = 10;
    localparam int COL_W   = 10;
    localparam int ROW_W   = 9;
    localparam int DIV_W   = 2;

    typedef logic [H_CNT_W-1:0] h_cnt_t;
    typedef logic [V_CNT_W-1:0] v_cnt_t;
    typedef logic [DIV_W-1:0]   div_cnt_t;

    // Everything that is decoded from one (h_cnt, v_cnt) position
    typedef struct packed {
        logic             hsync;
        logic             vsync;
        logic             video_on;
        logic [COL_W-1:0] column;
        logic [ROW_W-1:0] row;
    } vga_pix_t;

    localparam vga_pix_t PIX_IDLE = '{
        hsync:    ~SYNC_ACTIVE,
        vsync:    ~SYNC_ACTIVE,
        video_on: 1'b0,
        column:   10'd0,
        row:      9'd0
    };

    // True when cnt lies in the inclusive window [lo, hi]
    function automatic logic in_window(input h_cnt_t cnt, input h_cnt_t lo, input h_cnt_t hi);
        return (cnt >= lo) && (cnt <= hi);
    endfunction

endpackage

// File: rtl/vga_pix_div.sv
// Pixel clock-enable divider: produces a one-clock strobe every CLK_DIV
// system clocks. The strobe is registered and always equals
// (count == CLK_DIV-1), so with CLK_DIV=1 it stays high continuously.
module vga_pix_div
    import vga_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_D
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic pix_en_o
);

    localparam div_cnt_t DIV_LAST = div_cnt_t'(CLK_DIV - 1);

    div_cnt_t div_cnt_r;
    div_cnt_t div_cnt_next_s;
    logic     strobe_r;

    // Next divider count, wrapping after CLK_DIV-1
    always_comb begin
        div_cnt_next_s = 2'd0;
        if (div_cnt_r == DIV_LAST) begin
            div_cnt_next_s = 2'd0;
        end else begin
            div_cnt_next_s = div_cnt_r + 2'd1;
        end
    end

    // Divider count and look-ahead strobe register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_cnt_r <= 2'd0;
            strobe_r  <= (DIV_LAST == 2'd0);
        end else begin
            div_cnt_r <= div_cnt_next_s;
            strobe_r  <= (div_cnt_next_s == DIV_LAST);
        end
    end

    assign pix_en_o = strobe_r;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA sync generator: horizontal/vertical scan counters advanced by the
// pixel strobe, with sync, visible-area and coordinate decode captured into
// output registers on the same edge the counters advance.
module vga_sync_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_D,
    parameter int H_FP     = H_FP_D,
    parameter int H_SYNC   = H_SYNC_D,
    parameter int H_BP     = H_BP_D,
    parameter int V_ACTIVE = V_ACTIVE_D,
    parameter int V_FP     = V_FP_D,
    parameter int V_SYNC   = V_SYNC_D,
    parameter int V_BP     = V_BP_D,
    parameter int CLK_DIV  = CLK_DIV_D
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic        video_on_o,
    output logic [9:0]  column_o,
    output logic [8:0]  row_o,
    output logic        pix_en_o,
    output logic        frame_start_o
);

    // Counter bounds derived from the timing parameters
    localparam h_cnt_t H_LAST = h_cnt_t'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam v_cnt_t V_LAST = v_cnt_t'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam h_cnt_t H_VIS  = h_cnt_t'(H_ACTIVE);
    localparam v_cnt_t V_VIS  = v_cnt_t'(V_ACTIVE);
    localparam h_cnt_t HS_LO  = h_cnt_t'(H_ACTIVE + H_FP);
    localparam h_cnt_t HS_HI  = h_cnt_t'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam v_cnt_t VS_LO  = v_cnt_t'(V_ACTIVE + V_FP);
    localparam v_cnt_t VS_HI  = v_cnt_t'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic     pix_stb_s;
    h_cnt_t   h_cnt_r;
    v_cnt_t   v_cnt_r;
    h_cnt_t   h_next_s;
    v_cnt_t   v_next_s;
    logic     origin_s;
    vga_pix_t pix_s;
    vga_pix_t pix_r;
    logic     pix_en_r;
    logic     frame_start_r;

    vga_pix_div #(
        .CLK_DIV (CLK_DIV)
    ) u_pix_div (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .pix_en_o (pix_stb_s)
    );

    // Next scan position: h wraps at line end, v advances only on that wrap
    always_comb begin
        h_next_s = 10'd0;
        v_next_s = v_cnt_r;
        if (h_cnt_r == H_LAST) begin
            h_next_s = 10'd0;
            if (v_cnt_r == V_LAST) begin
                v_next_s = 10'd0;
            end else begin
                v_next_s = v_cnt_r + 10'd1;
            end
        end else begin
            h_next_s = h_cnt_r + 10'd1;
            v_next_s = v_cnt_r;
        end
    end

    // Decode of the current scan position into the values to be registered
    always_comb begin
        pix_s          = PIX_IDLE;
        origin_s       = (h_cnt_r == 10'd0) && (v_cnt_r == 10'd0);
        pix_s.video_on = (h_cnt_r < H_VIS) && (v_cnt_r < V_VIS);
        pix_s.hsync    = in_window(h_cnt_r, HS_LO, HS_HI) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        pix_s.vsync    = in_window(v_cnt_r, VS_LO, VS_HI) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        if (pix_s.video_on) begin
            pix_s.column = h_cnt_r;
            pix_s.row    = v_cnt_r[8:0];
        end else begin
            pix_s.column = 10'd0;
            pix_s.row    = 9'd0;
        end
    end

    // Scan counters and output registers, all advancing on the pixel strobe
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            h_cnt_r       <= 10'd0;
            v_cnt_r       <= 10'd0;
            pix_r         <= PIX_IDLE;
            pix_en_r      <= 1'b0;
            frame_start_r <= 1'b0;
        end else begin
            pix_en_r      <= pix_stb_s;
            frame_start_r <= pix_stb_s && origin_s;
            if (pix_stb_s) begin
                h_cnt_r <= h_next_s;
                v_cnt_r <= v_next_s;
                pix_r   <= pix_s;
            end else begin
                h_cnt_r <= h_cnt_r;
                v_cnt_r <= v_cnt_r;
                pix_r   <= pix_r;
            end
        end
    end

    assign hsync_o       = pix_r.hsync;
    assign vsync_o       = pix_r.vsync;
    assign video_on_o    = pix_r.video_on;
    assign column_o      = pix_r.column;
    assign row_o         = pix_r.row;
    assign pix_en_o      = pix_en_r;
    assign frame_start_o = frame_start_r;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Self-checking bench for vga_sync_gen. Three instances run side by side:
// A uses the default 640x480 mode with CLK_DIV=2, B and C use a tiny mode
// (25x13 pixels) with CLK_DIV=3 and CLK_DIV=1 so whole frames fit quickly.
// Expected outputs come from a pixel-index model: after k non-reset edges the
// outputs show pixel k/D-1 of the scan (reset values while k < D).
module tb_vga_sync_gen;

    localparam int SHA = 16, SHF = 2, SHS = 3, SHB = 4;
    localparam int SVA = 6,  SVF = 2, SVS = 2, SVB = 3;
    localparam int SHT = SHA + SHF + SHS + SHB;
    localparam int SVT = SVA + SVF + SVS + SVB;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b, rst_c;
    logic hs_a, vs_a, vid_a, pe_a, fs_a;
    logic hs_b, vs_b, vid_b, pe_b, fs_b;
    logic hs_c, vs_c, vid_c, pe_c, fs_c;
    logic [9:0] col_a, col_b, col_c;
    logic [8:0] row_a, row_b, row_c;
    logic [23:0] obs_a, obs_b, obs_c, exp_v;

    int k_a, k_b, k_c;
    int checks = 0;
    int failures = 0;

    localparam logic [23:0] IDLE = {1'b1, 1'b1, 1'b1 ^ 1'b1, 10'd0, 9'd0, 1'b0, 1'b0};

    assign obs_a = {hs_a, vs_a, vid_a, col_a, row_a, pe_a, fs_a};
    assign obs_b = {hs_b, vs_b, vid_b, col_b, row_b, pe_b, fs_b};
    assign obs_c = {hs_c, vs_c, vid_c, col_c, row_c, pe_c, fs_c};

    vga_sync_gen u_dut_a (
        .clk_i (clk), .rst_i (rst_a), .hsync_o (hs_a), .vsync_o (vs_a),
        .video_on_o (vid_a), .column_o (col_a), .row_o (row_a),
        .pix_en_o (pe_a), .frame_start_o (fs_a)
    );

    vga_sync_gen #(
        .H_ACTIVE (SHA), .H_FP (SHF), .H_SYNC (SHS), .H_BP (SHB),
        .V_ACTIVE (SVA), .V_FP (SVF), .V_SYNC (SVS), .V_BP (SVB), .CLK_DIV (3)
    ) u_dut_b (
        .clk_i (clk), .rst_i (rst_b), .hsync_o (hs_b), .vsync_o (vs_b),
        .video_on_o (vid_b), .column_o (col_b), .row_o (row_b),
        .pix_en_o (pe_b), .frame_start_o (fs_b)
    );

    vga_sync_gen #(
        .H_ACTIVE (SHA), .H_FP (SHF), .H_SYNC (SHS), .H_BP (SHB),
        .V_ACTIVE (SVA), .V_FP (SVF), .V_SYNC (SVS), .V_BP (SVB), .CLK_DIV (1)
    ) u_dut_c (
        .clk_i (clk), .rst_i (rst_c), .hsync_o (hs_c), .vsync_o (vs_c),
        .video_on_o (vid_c), .column_o (col_c), .row_o (row_c),
        .pix_en_o (pe_c), .frame_start_o (fs_c)
    );

    // Expected {hsync, vsync, video_on, column, row, pix_en, frame_start}
    function automatic logic [23:0] model(input int k, input int d,
                                          input int ha, input int hfp, input int hs, input int hbp,
                                          input int va, input int vfp, input int vs, input int vbp);
        int ht, vt, p, x, y;
        logic vid, hsn, vsn, pe, fs;
        logic [9:0] col;
        logic [8:0] row;
        ht = ha + hfp + hs + hbp;
        vt = va + vfp + vs + vbp;
        if (k < d) return {1'b1, 1'b1, 1'b0, 10'd0, 9'd0, 1'b0, 1'b0};
        p   = (k / d - 1) % (ht * vt);
        x   = p % ht;
        y   = p / ht;
        vid = (x < ha) && (y < va);
        hsn = !((x >= ha + hfp) && (x < ha + hfp + hs));
        vsn = !((y >= va + vfp) && (y < va + vfp + vs));
        col = vid ? 10'(x) : 10'd0;
        row = vid ? 9'(y) : 9'd0;
        pe  = (k % d) == 0;
        fs  = pe && (p == 0);
        return {hsn, vsn, vid, col, row, pe, fs};
    endfunction

    function automatic logic [23:0] model_a(input int k);
        return model(k, 2, 640, 16, 96, 48, 480, 10, 2, 33);
    endfunction
    function automatic logic [23:0] model_b(input int k);
        return model(k, 3, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB);
    endfunction
    function automatic logic [23:0] model_c(input int k);
        return model(k, 1, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB);
    endfunction

    // One clock: track non-reset edges per instance, then settle past the edge
    task automatic tick();
        @(posedge clk);
        k_a = rst_a ? 0 : k_a + 1;
        k_b = rst_b ? 0 : k_b + 1;
        k_c = rst_c ? 0 : k_c + 1;
        #1;
    endtask

    task automatic test_reset();
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        k_a = 0; k_b = 0; k_c = 0;
        repeat (3) tick();
        checks++;
        if (obs_a !== IDLE) begin
            failures++; $display("FAIL reset_a got=%h exp=%h", obs_a, IDLE);
        end
        checks++;
        if (obs_b !== IDLE) begin
            failures++; $display("FAIL reset_b got=%h exp=%h", obs_b, IDLE);
        end
        checks++;
        if (obs_c !== IDLE) begin
            failures++; $display("FAIL reset_c got=%h exp=%h", obs_c, IDLE);
        end
    endtask

    task automatic test_first_pixel();
        logic [23:0] first_exp;
        first_exp = {1'b1, 1'b1, 1'b1, 10'd0, 9'd0, 1'b1, 1'b1};
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            exp_v = model_a(k_a);
            checks++;
            if (obs_a !== exp_v) begin
                failures++; $display("FAIL first_a k=%0d got=%h exp=%h", k_a, obs_a, exp_v);
            end
            exp_v = model_b(k_b);
            checks++;
            if (obs_b !== exp_v) begin
                failures++; $display("FAIL first_b k=%0d got=%h exp=%h", k_b, obs_b, exp_v);
            end
            exp_v = model_c(k_c);
            checks++;
            if (obs_c !== exp_v) begin
                failures++; $display("FAIL first_c k=%0d got=%h exp=%h", k_c, obs_c, exp_v);
            end
            if (i == 2) begin
                checks++;
                if (obs_a !== first_exp) begin
                    failures++; $display("FAIL first_pixel_a got=%h exp=%h", obs_a, first_exp);
                end
            end
        end
    endtask

    task automatic test_free_run();
        int hs_cnt, hs_first, line1_k, vs_cnt, vs_first_line, fs_cnt_c, fs_prev_c, fs_gap_c;
        hs_cnt = 0; hs_first = -1; line1_k = -1;
        vs_cnt = 0; vs_first_line = -1;
        fs_cnt_c = 0; fs_prev_c = -1; fs_gap_c = -1;
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        tick();
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        for (int i = 0; i < 1650; i++) begin
            tick();
            exp_v = model_a(k_a);
            checks++;
            if (obs_a !== exp_v) begin
                failures++; $display("FAIL run_a k=%0d got=%h exp=%h", k_a, obs_a, exp_v);
            end
            exp_v = model_b(k_b);
            checks++;
            if (obs_b !== exp_v) begin
                failures++; $display("FAIL run_b k=%0d got=%h exp=%h", k_b, obs_b, exp_v);
            end
            exp_v = model_c(k_c);
            checks++;
            if (obs_c !== exp_v) begin
                failures++; $display("FAIL run_c k=%0d got=%h exp=%h", k_c, obs_c, exp_v);
            end
            if (pe_a && (k_a / 2 - 1) < 800 && !hs_a) begin
                if (hs_first < 0) hs_first = k_a / 2 - 1;
                hs_cnt++;
            end
            if (pe_a && vid_a && col_a == 10'd0 && row_a == 9'd1 && line1_k < 0) line1_k = k_a;
            if (pe_b && (k_b / 3 - 1) < SHT * SVT && !vs_b) begin
                if (vs_first_line < 0) vs_first_line = (k_b / 3 - 1) / SHT;
                vs_cnt++;
            end
            if (fs_c) begin
                if (fs_prev_c >= 0) fs_gap_c = k_c - fs_prev_c;
                fs_prev_c = k_c;
                fs_cnt_c++;
            end
        end
        checks++;
        if (hs_cnt !== 96) begin
            failures++; $display("FAIL hsync_width got=%0d exp=96", hs_cnt);
        end
        checks++;
        if (hs_first !== 656) begin
            failures++; $display("FAIL hsync_start got=%0d exp=656", hs_first);
        end
        checks++;
        if (line1_k !== 1602) begin
            failures++; $display("FAIL line_period got=%0d exp=1602", line1_k);
        end
        checks++;
        if (vs_cnt !== SVS * SHT) begin
            failures++; $display("FAIL vsync_width got=%0d exp=%0d", vs_cnt, SVS * SHT);
        end
        checks++;
        if (vs_first_line !== SVA + SVF) begin
            failures++; $display("FAIL vsync_start got=%0d exp=%0d", vs_first_line, SVA + SVF);
        end
        checks++;
        if (fs_cnt_c !== 6) begin
            failures++; $display("FAIL frame_count_c got=%0d exp=6", fs_cnt_c);
        end
        checks++;
        if (fs_gap_c !== SHT * SVT) begin
            failures++; $display("FAIL frame_period_c got=%0d exp=%0d", fs_gap_c, SHT * SVT);
        end
    endtask

    task automatic test_mid_frame_reset();
        int budget;
        logic [23:0] first_exp;
        first_exp = {1'b1, 1'b1, 1'b1, 10'd0, 9'd0, 1'b1, 1'b1};
        budget = 0;
        while (!(pe_b && vid_b && row_b == 9'd4 && col_b == 10'd10) && budget < 3000) begin
            tick();
            budget++;
        end
        checks++;
        if (budget >= 3000) begin
            failures++; $display("FAIL midreset_wait got=timeout exp=pixel(10,4)");
        end
        rst_b = 1'b1;
        tick();
        rst_b = 1'b0;
        checks++;
        if (obs_b !== IDLE) begin
            failures++; $display("FAIL midreset_idle got=%h exp=%h", obs_b, IDLE);
        end
        repeat (3) tick();
        checks++;
        if (obs_b !== first_exp) begin
            failures++; $display("FAIL midreset_restart got=%h exp=%h", obs_b, first_exp);
        end
    endtask

    task automatic test_random_reset();
        for (int i = 0; i < 4000; i++) begin
            rst_a = ($urandom_range(0, 999) == 0);
            rst_b = ($urandom_range(0, 299) == 0);
            rst_c = ($urandom_range(0, 199) == 0);
            tick();
            exp_v = model_a(k_a);
            checks++;
            if (obs_a !== exp_v) begin
                failures++; $display("FAIL rand_a k=%0d got=%h exp=%h", k_a, obs_a, exp_v);
            end
            exp_v = model_b(k_b);
            checks++;
            if (obs_b !== exp_v) begin
                failures++; $display("FAIL rand_b k=%0d got=%h exp=%h", k_b, obs_b, exp_v);
            end
            exp_v = model_c(k_c);
            checks++;
            if (obs_c !== exp_v) begin
                failures++; $display("FAIL rand_c k=%0d got=%h exp=%h", k_c, obs_c, exp_v);
            end
        end
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        test_reset();
        test_first_pixel();
        test_free_run();
        test_mid_frame_reset();
        test_random_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
